// File: rtl/regfile_arbiter_if.sv
// Requester-side command/response bundle for regfile_arbiter: valid/ready commands in, one-cycle response pulses out.
// Port [i] of every field belongs to requester i; no response backpressure.
interface regfile_arbiter_if #(parameter int DATA_W = 8);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_rw;
  logic [1:0]          req_wsel;
  logic [3:0]          req_rsel;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_read0;
  logic [DATA_W-1:0]   rsp_read1;

  modport slave (
    input  req_valid, req_rw, req_wsel, req_rsel, req_wdata,
    output req_ready, rsp_valid, rsp_read0, rsp_read1
  );

  modport master (
    output req_valid, req_rw, req_wsel, req_rsel, req_wdata,
    input  req_ready, rsp_valid, rsp_read0, rsp_read1
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin 2-requester arbiter for the A/B regfile; 3 cycles per op (IDLE accept, ISSUE, RESP), ready only in IDLE.
// Define REGFILE_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins); responses cannot be stalled.
module regfile_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              sysclk_i,
  input  logic              rst_i,
  regfile_arbiter_if.slave  req_if,
  output logic              rf_rw_o,
  output logic              rf_wsel_o,
  output logic [1:0]        rf_rsel_o,
  output logic [DATA_W-1:0] rf_w_o,
  input  logic [DATA_W-1:0] rf_read0_i,
  input  logic [DATA_W-1:0] rf_read1_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              rw_q, rw_d;
  logic              rf_rw_q, rf_rw_d;
  logic              rf_wsel_q, rf_wsel_d;
  logic [1:0]        rf_rsel_q, rf_rsel_d;
  logic [DATA_W-1:0] rf_w_q, rf_w_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;

  logic [1:0]        vld;
  logic              win;
  logic [1:0]        ready;
  logic [1:0]        rsp_vld;
  logic [DATA_W-1:0] rsp_rd0;
  logic [DATA_W-1:0] rsp_rd1;

  assign vld = req_if.req_valid;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  assign win = ~vld[0];
`else
  logic last_grant_q, last_grant_d;

  // Contended cycles go to whoever did not win last; otherwise the sole requester.
  assign win = (&vld) ? ~last_grant_q : vld[1];

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && (|vld)) begin
      last_grant_d = win;
    end
  end

  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rw_d      = rw_q;
    rf_rw_d   = 1'b0;
    rf_wsel_d = rf_wsel_q;
    rf_rsel_d = rf_rsel_q;
    rf_w_d    = rf_w_q;
    rd0_d     = rd0_q;
    rd1_d     = rd1_q;
    ready     = 2'b00;
    rsp_vld   = 2'b00;
    rsp_rd0   = rd0_q;
    rsp_rd1   = rd1_q;
    unique case (state_q)
      IDLE: begin
        if (|vld) begin
          ready     = win ? 2'b10 : 2'b01;
          grant_d   = win;
          rw_d      = req_if.req_rw[win];
          rf_rw_d   = req_if.req_rw[win];
          rf_wsel_d = req_if.req_wsel[win];
          rf_rsel_d = win ? req_if.req_rsel[3:2] : req_if.req_rsel[1:0];
          rf_w_d    = win ? req_if.req_wdata[2*DATA_W-1:DATA_W]
                          : req_if.req_wdata[DATA_W-1:0];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        state_d = RESP;
      end
      RESP: begin
        rsp_vld = grant_q ? 2'b10 : 2'b01;
        // Regfile read data is registered, so it lands exactly in this cycle.
        if (!rw_q) begin
          rsp_rd0 = rf_read0_i;
          rsp_rd1 = rf_read1_i;
          rd0_d   = rf_read0_i;
          rd1_d   = rf_read1_i;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      rw_q      <= 1'b0;
      rf_rw_q   <= 1'b0;
      rf_wsel_q <= 1'b0;
      rf_rsel_q <= 2'b00;
      rf_w_q    <= '0;
      rd0_q     <= '0;
      rd1_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rw_q      <= rw_d;
      rf_rw_q   <= rf_rw_d;
      rf_wsel_q <= rf_wsel_d;
      rf_rsel_q <= rf_rsel_d;
      rf_w_q    <= rf_w_d;
      rd0_q     <= rd0_d;
      rd1_q     <= rd1_d;
    end
  end

  assign req_if.req_ready = ready;
  assign req_if.rsp_valid = rsp_vld;
  assign req_if.rsp_read0 = rsp_rd0;
  assign req_if.rsp_read1 = rsp_rd1;
  assign rf_rw_o          = rf_rw_q;
  assign rf_wsel_o        = rf_wsel_q;
  assign rf_rsel_o        = rf_rsel_q;
  assign rf_w_o           = rf_w_q;

endmodule
